// File: rtl/neokeon_iter_rotator_if.sv
// neokeon_iter_rotator_if: request/result bundle for the iterative word rotator
interface neokeon_iter_rotator_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
);
   logic               inStart;
   logic               inDir;
   logic [SHAMT_W-1:0] inAmount;
   logic [WIDTH-1:0]   inDataWord;
   logic [WIDTH-1:0]   outputData;
   logic               outBusy;
   logic               outValid;
   modport master (output inStart, inDir, inAmount, inDataWord, input outputData, outBusy, outValid);
   modport slave  (input inStart, inDir, inAmount, inDataWord, output outputData, outBusy, outValid);
endinterface

// File: rtl/neokeon_iter_rotator.sv
// neokeon_iter_rotator: rotates a word one bit per clock through a single rotate-by-1 stage
module neokeon_iter_rotator #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input logic                   inClk,
   input logic                   inRst,
   neokeon_iter_rotator_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;
   state_t             state_q, state_d;
   logic [WIDTH-1:0]   work_q, work_d, data_q, data_d, rot1;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               dir_q, dir_d, accept;
   assign rot1   = dir_q ? {work_q[WIDTH-2:0], work_q[WIDTH-1]} : {work_q[0], work_q[WIDTH-1:1]};
   assign accept = bus.inStart && (state_q != ROT);
   // next state: accept in IDLE/DONE, one rotate step per cycle in ROT
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      if (state_q == ROT) begin
         work_d = rot1;
         cnt_d  = cnt_q - 1'b1;
         if (cnt_q == SHAMT_W'(1)) begin
            state_d = DONE;
            data_d  = rot1;
         end
      end else if (accept) begin
         work_d  = bus.inDataWord;
         dir_d   = bus.inDir;
         cnt_d   = bus.inAmount;
         state_d = (bus.inAmount == '0) ? DONE : ROT;
         data_d  = (bus.inAmount == '0) ? bus.inDataWord : data_q;
      end else begin
         state_d = IDLE;
      end
   end
   // state and datapath registers; reset discards any rotation in progress
   always_ff @(posedge inClk) begin
      if (inRst) begin
         state_q <= IDLE;
         work_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
      end
   end
   assign bus.outputData = data_q;
   assign bus.outBusy    = (state_q == ROT);
   assign bus.outValid   = (state_q == DONE);
endmodule

// File: tb/tb_neokeon_iter_rotator.sv
// tb_neokeon_iter_rotator: randomized and directed checks against a shift-based rotation model
module tb_neokeon_iter_rotator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   neokeon_iter_rotator_if #(.WIDTH(32), .SHAMT_W(5)) bus ();
   neokeon_iter_rotator_if #(.WIDTH(16), .SHAMT_W(4)) bus16 ();
   neokeon_iter_rotator #(.WIDTH(32), .SHAMT_W(5)) dut (.inClk(clk), .inRst(rst), .bus(bus));
   neokeon_iter_rotator #(.WIDTH(16), .SHAMT_W(4)) dut16 (.inClk(clk), .inRst(rst), .bus(bus16));
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_rot(input logic [31:0] w, input logic dir, input int amt);
      int          k;
      logic [63:0] d;
      k = dir ? (32 - amt) % 32 : amt;
      d = {w, w} >> k;
      return d[31:0];
   endfunction

   function automatic logic [15:0] ref_rot16(input logic [15:0] w, input logic dir, input int amt);
      int          k;
      logic [31:0] d;
      k = dir ? (16 - amt) % 16 : amt;
      d = {w, w} >> k;
      return d[15:0];
   endfunction

   task automatic start_op(input logic [31:0] w, input logic dir, input int amt);
      @(negedge clk);
      bus.inStart    = 1'b1;
      bus.inDataWord = w;
      bus.inDir      = dir;
      bus.inAmount   = 5'(amt);
      @(negedge clk);
      bus.inStart = 1'b0;
   endtask

   task automatic wait_done(input int first, output int cyc, output int busy_cnt);
      cyc      = first;
      busy_cnt = 0;
      while (!bus.outValid && cyc < 100) begin
         if (bus.outBusy) busy_cnt++;
         @(negedge clk);
         cyc++;
      end
      if (!bus.outValid) cyc = -1;
   endtask

   task automatic check_op(input string name, input logic [31:0] w, input logic dir, input int amt);
      int          cyc, busy_cnt;
      logic [31:0] exp;
      exp = ref_rot(w, dir, amt);
      start_op(w, dir, amt);
      wait_done(1, cyc, busy_cnt);
      n_checks++;
      if (cyc !== amt + 1) begin
         n_fail++;
         $display("FAIL %s latency: got %0d expected %0d", name, cyc, amt + 1);
      end
      n_checks++;
      if (busy_cnt !== amt) begin
         n_fail++;
         $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_cnt, amt);
      end
      n_checks++;
      if (bus.outputData !== exp) begin
         n_fail++;
         $display("FAIL %s data: got %h expected %h", name, bus.outputData, exp);
      end
      @(negedge clk);
      n_checks++;
      if (bus.outValid !== 1'b0 || bus.outputData !== exp) begin
         n_fail++;
         $display("FAIL %s after pulse: valid %b data %h expected valid 0 data %h", name, bus.outValid, bus.outputData, exp);
      end
   endtask

   task automatic test_reset();
      n_checks++;
      if (bus.outBusy !== 1'b0 || bus.outValid !== 1'b0 || bus.outputData !== 32'h0) begin
         n_fail++;
         $display("FAIL reset32: busy %b valid %b data %h expected 0 0 0", bus.outBusy, bus.outValid, bus.outputData);
      end
      n_checks++;
      if (bus16.outBusy !== 1'b0 || bus16.outValid !== 1'b0 || bus16.outputData !== 16'h0) begin
         n_fail++;
         $display("FAIL reset16: busy %b valid %b data %h expected 0 0 0", bus16.outBusy, bus16.outValid, bus16.outputData);
      end
   endtask

   task automatic test_directed();
      check_op("rotr1", 32'h1111aaaa, 1'b0, 1);
      check_op("rotl5", 32'h80000001, 1'b1, 5);
      check_op("rotr27", 32'h80000001, 1'b0, 27);
      n_checks++;
      if (bus.outputData !== 32'h00000030) begin
         n_fail++;
         $display("FAIL rotr27 literal: got %h expected 00000030", bus.outputData);
      end
      check_op("amount0", 32'hdeadbeef, 1'b0, 0);
      check_op("rotr31", 32'h1111aaaa, 1'b0, 31);
      n_checks++;
      if (bus.outputData !== 32'h22235554) begin
         n_fail++;
         $display("FAIL rotr31 literal: got %h expected 22235554", bus.outputData);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, busy_cnt;
      start_op(32'h12345678, 1'b0, 8);
      @(negedge clk);
      bus.inStart    = 1'b1;
      bus.inDataWord = 32'hffff0000;
      bus.inDir      = 1'b1;
      bus.inAmount   = 5'd3;
      @(negedge clk);
      bus.inStart = 1'b0;
      wait_done(3, cyc, busy_cnt);
      n_checks++;
      if (cyc !== 9 || bus.outputData !== 32'h78123456) begin
         n_fail++;
         $display("FAIL b2b first: cycle %0d data %h expected cycle 9 data 78123456", cyc, bus.outputData);
      end
      bus.inStart    = 1'b1;
      bus.inDataWord = 32'h00000001;
      bus.inDir      = 1'b1;
      bus.inAmount   = 5'd1;
      @(negedge clk);
      bus.inStart = 1'b0;
      n_checks++;
      if (bus.outBusy !== 1'b1 || bus.outValid !== 1'b0 || bus.outputData !== 32'h78123456) begin
         n_fail++;
         $display("FAIL b2b hold: busy %b valid %b data %h expected 1 0 78123456", bus.outBusy, bus.outValid, bus.outputData);
      end
      @(negedge clk);
      n_checks++;
      if (bus.outValid !== 1'b1 || bus.outputData !== 32'h00000002) begin
         n_fail++;
         $display("FAIL b2b second: valid %b data %h expected 1 00000002", bus.outValid, bus.outputData);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [31:0] w;
      w = $urandom;
      start_op(w, 1'b1, 20);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (bus.outBusy !== 1'b0 || bus.outValid !== 1'b0 || bus.outputData !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid: busy %b valid %b data %h expected 0 0 0", bus.outBusy, bus.outValid, bus.outputData);
      end
      bus.inStart    = 1'b1;
      bus.inDataWord = 32'hcafef00d;
      bus.inAmount   = 5'd0;
      rst            = 1'b1;
      @(negedge clk);
      rst         = 1'b0;
      bus.inStart = 1'b0;
      n_checks++;
      if (bus.outValid !== 1'b0 || bus.outBusy !== 1'b0 || bus.outputData !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_vs_start: valid %b busy %b data %h expected 0 0 0", bus.outValid, bus.outBusy, bus.outputData);
      end
      check_op("after_reset", w, 1'b1, 20);
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++)
         check_op("random", $urandom, 1'($urandom_range(1)), int'($urandom_range(31)));
   endtask

   task automatic test_width16();
      int          cyc;
      logic [15:0] w, exp;
      logic        dir;
      int          amt;
      for (int i = 0; i < 4; i++) begin
         w   = (i == 0) ? 16'h8001 : 16'($urandom);
         dir = (i == 0) ? 1'b0 : 1'($urandom_range(1));
         amt = (i == 0) ? 2 : int'($urandom_range(15));
         exp = ref_rot16(w, dir, amt);
         @(negedge clk);
         bus16.inStart    = 1'b1;
         bus16.inDataWord = w;
         bus16.inDir      = dir;
         bus16.inAmount   = 4'(amt);
         @(negedge clk);
         bus16.inStart = 1'b0;
         cyc = 1;
         while (!bus16.outValid && cyc < 100) begin
            @(negedge clk);
            cyc++;
         end
         n_checks++;
         if (cyc !== amt + 1 || bus16.outputData !== exp) begin
            n_fail++;
            $display("FAIL width16: cycle %0d data %h expected cycle %0d data %h", cyc, bus16.outputData, amt + 1, exp);
         end
      end
      n_checks++;
      if (ref_rot16(16'h8001, 1'b0, 2) !== 16'h6000 || bus16.outputData === 16'hxxxx) begin
         n_fail++;
         $display("FAIL width16 model: got %h expected 6000", ref_rot16(16'h8001, 1'b0, 2));
      end
   endtask

   initial begin
      bus.inStart      = 1'b0;
      bus.inDir        = 1'b0;
      bus.inAmount     = '0;
      bus.inDataWord   = '0;
      bus16.inStart    = 1'b0;
      bus16.inDir      = 1'b0;
      bus16.inAmount   = '0;
      bus16.inDataWord = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_width16();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/neokeon_iter_rotator.md
Name: neokeon_iter_rotator

Overview:
Parametrised, multi-cycle word rotator for the Neokeon datapath, generalising the fixed 32-bit rotate-right-by-1 function. It accepts a word, a direction and a rotate amount, then applies one single-bit rotation per clock, reusing one rotate-by-1 stage. It serves the Theta/Pi1/Pi2 steps (ROTL/ROTR by 1, 2, 5 and 8) where area matters more than latency.

Parameters:
WIDTH, 32, data word width in bits; must be a power of two and at least 2.
SHAMT_W, 5, width of the rotate amount; must equal clog2(WIDTH).

Ports:
inClk  input  1  system clock, rising edge.
inRst  input  1  synchronous active-high reset.
inStart  input  1  request strobe; sampled each rising edge.
inDir  input  1  0 = rotate right, 1 = rotate left; latched on accept.
inAmount  input  SHAMT_W  rotate amount, 0..WIDTH-1; latched on accept.
inDataWord  input  WIDTH  operand; latched on accept.
outputData  output  WIDTH  result register; valid while outValid=1, then held.
outBusy  output  1  high while rotation steps are in progress.
outValid  output  1  one-cycle completion pulse.

Behaviour:
- One clock (inClk); reset is synchronous and active-high (inRst). All state updates on the rising edge of inClk.
- Reset: state=IDLE, outputData=0, outBusy=0, outValid=0, counter=0. Reset applies in any state, including mid-rotation; the partial result is discarded.
- States: IDLE, ROT, DONE. outBusy=1 only in ROT. outValid=1 only in DONE. Both outputs are registered or decoded from state, with no combinational path from the inputs.
- Accept condition: inStart=1 while state is IDLE or DONE. On the accept edge the block latches inDataWord into the work register, inDir, and inAmount into the counter.
  - Next state is DONE if inAmount=0.
  - Otherwise next state is ROT.
- ROT, on each edge:
  - Work register rotates by exactly 1 bit in the latched direction. Right: {w[0], w[WIDTH-1:1]}. Left: {w[WIDTH-2:0], w[WIDTH-1]}.
  - Counter decrements.
  - When the counter steps from 1 to 0, next state is DONE.
- DONE: outValid=1 for exactly one cycle and outputData shows the final word.
  - Next state is IDLE, or ROT/DONE if a new request is accepted in the same cycle (back-to-back operation).
  - The DONE pulse and its result are not disturbed by that acceptance.
- Latency: outValid is high in the (N+1)th cycle after the accept edge, where N = latched amount. For N=0 this is 1 cycle; the maximum is WIDTH cycles.
- outputData updates only on transition into DONE. It holds its value in IDLE and during the next ROT phase.
- inStart while in ROT is ignored and not queued. inputs changing during ROT have no effect.
- Wrap-around: rotation is modular. ROTR by k equals ROTL by WIDTH-k; amount 0 is the identity.
- Simultaneous inRst and inStart: reset wins and nothing is accepted.

Test Plan:
1. WIDTH=32; inDataWord=32'h1111aaaa, inDir=0, inAmount=1, one-cycle inStart -> outBusy high 1 cycle; outValid pulses on cycle 2; outputData=32'h0888d555.
2. inDataWord=32'h80000001, inDir=1, inAmount=5 -> outBusy high 5 cycles; outValid on cycle 6; outputData=32'h00000030. Repeat with inDir=0, inAmount=27 -> same result 32'h00000030, outValid on cycle 28.
3. inAmount=0, inDataWord=32'hdeadbeef -> outBusy never asserts; outValid on cycle 1; outputData=32'hdeadbeef. Then inAmount=31, inDir=0 on 32'h1111aaaa -> 32'h22235554 after 32 cycles.
4. Start ROTR by 8 on 32'h12345678; pulse inStart with other data during ROT; issue a new start (ROTL 1, 32'h00000001) in the DONE cycle -> first result 32'h78123456; the mid-ROT start is ignored; the second result 32'h00000002 follows 2 cycles later.
5. Reset mid-rotation: start ROTL by 20, assert inRst on cycle 7 -> next cycle outBusy=0, outValid=0, outputData=0, state IDLE. A fresh request afterwards completes correctly.
6. WIDTH=16, SHAMT_W=4: 16'h8001, inDir=0, inAmount=2 -> outValid on cycle 3, outputData=16'h6000.
